// File: rtl/trigger_detector_if.sv
// Probe, configuration and status bundle for trigger_detector.
// o_trig_time exists only when TRIG_TIMESTAMP_EN is defined.
interface trigger_detector_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] i_data;
    logic             i_arm;
    logic             i_abort;
    logic [WIDTH-1:0] i_rise_en;
    logic [WIDTH-1:0] i_fall_en;
    logic [WIDTH-1:0] i_level_mask;
    logic [WIDTH-1:0] i_level_value;
    logic             i_combine_and;
    logic [CNT_W-1:0] i_count;
    logic [CNT_W-1:0] i_holdoff;
    logic             o_armed;
    logic             o_triggered;
    logic             o_done;
    logic [CNT_W-1:0] o_match_cnt;
    logic             o_changed;
`ifdef TRIG_TIMESTAMP_EN
    logic [CNT_W-1:0] o_trig_time;
`endif

    modport master (
        output i_data, i_arm, i_abort, i_rise_en, i_fall_en, i_level_mask,
               i_level_value, i_combine_and, i_count, i_holdoff,
`ifdef TRIG_TIMESTAMP_EN
        input  o_trig_time,
`endif
        input  o_armed, o_triggered, o_done, o_match_cnt, o_changed
    );

    modport slave (
        input  i_data, i_arm, i_abort, i_rise_en, i_fall_en, i_level_mask,
               i_level_value, i_combine_and, i_count, i_holdoff,
`ifdef TRIG_TIMESTAMP_EN
        output o_trig_time,
`endif
        output o_armed, o_triggered, o_done, o_match_cnt, o_changed
    );
endinterface

// File: rtl/trigger_detector.sv
// Edge/level trigger unit with arm, holdoff and occurrence counting.
// Define TRIG_TIMESTAMP_EN to add o_trig_time (cycles spent ARMED before trigger).
module trigger_detector #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    trigger_detector_if.slave bus
);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_HOLDOFF, S_ARMED, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_fire;

    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_level_mask;
    logic [WIDTH-1:0] r_level_value;
    logic             r_combine_and;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_holdoff;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] r_match_cnt;
    logic             r_trig;

    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_hit;
    logic [WIDTH-1:0] w_edge_en;
    logic             w_edge_ok;
    logic             w_level_ok;
    logic             w_match;
    logic [CNT_W-1:0] w_target;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_rise     = bus.i_data & ~r_prev;
    assign w_fall     = ~bus.i_data & r_prev;
    assign w_hit      = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_edge_en  = r_rise_en | r_fall_en;
    assign w_edge_ok  = (w_edge_en == '0) ? 1'b1 :
                        (r_combine_and ? &(~w_edge_en | w_hit) : |w_hit);
    assign w_level_ok = &(~r_level_mask | ~(bus.i_data ^ r_level_value));
    assign w_match    = w_edge_ok & w_level_ok;

    assign w_target  = (r_count == '0) ? ONE : r_count;
    assign w_cnt_inc = (r_match_cnt == '1) ? r_match_cnt : r_match_cnt + ONE;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Abort outranks arm; arm restarts from any state.
    always_comb begin
        w_next = r_state;
        w_fire = 1'b0;
        if (bus.i_abort) begin
            w_next = S_IDLE;
        end else if (bus.i_arm) begin
            w_next = (bus.i_holdoff != '0) ? S_HOLDOFF : S_ARMED;
        end else begin
            case (r_state)
                S_HOLDOFF: if (r_hold_cnt == r_holdoff - ONE) w_next = S_ARMED;
                S_ARMED: begin
                    if (w_match && (w_cnt_inc == w_target)) begin
                        w_next = S_DONE;
                        w_fire = 1'b1;
                    end
                end
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        r_prev <= bus.i_data;
        if (i_rst) begin
            r_rise_en     <= '0;
            r_fall_en     <= '0;
            r_level_mask  <= '0;
            r_level_value <= '0;
            r_combine_and <= 1'b0;
            r_count       <= '0;
            r_holdoff     <= '0;
            r_hold_cnt    <= '0;
            r_match_cnt   <= '0;
            r_trig        <= 1'b0;
        end else begin
            r_trig <= w_fire;
            if (!bus.i_abort && bus.i_arm) begin
                r_rise_en     <= bus.i_rise_en;
                r_fall_en     <= bus.i_fall_en;
                r_level_mask  <= bus.i_level_mask;
                r_level_value <= bus.i_level_value;
                r_combine_and <= bus.i_combine_and;
                r_count       <= bus.i_count;
                r_holdoff     <= bus.i_holdoff;
                r_hold_cnt    <= '0;
                r_match_cnt   <= '0;
            end else if (!bus.i_abort) begin
                if (r_state == S_HOLDOFF) r_hold_cnt <= r_hold_cnt + ONE;
                if (r_state == S_ARMED && w_match) r_match_cnt <= w_cnt_inc;
            end
        end
    end

`ifdef TRIG_TIMESTAMP_EN
    logic [CNT_W-1:0] r_time;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_time <= '0;
        end else if (!bus.i_abort && bus.i_arm) begin
            r_time <= '0;
        end else if (!bus.i_abort && r_state == S_ARMED && r_time != '1) begin
            r_time <= r_time + ONE;
        end
    end

    assign bus.o_trig_time = r_time;
`endif

    assign bus.o_armed     = (r_state == S_HOLDOFF) || (r_state == S_ARMED);
    assign bus.o_triggered = r_trig;
    assign bus.o_done      = (r_state == S_DONE);
    assign bus.o_match_cnt = r_match_cnt;
    assign bus.o_changed   = |(bus.i_data ^ r_prev);
endmodule

// File: tb/tb_trigger_detector.sv
// Directed and randomized checks of trigger_detector against a cycle-indexed
// reference model (arm cycle + holdoff window, match count, done flag).
module tb_trigger_detector;
    logic clk;
    logic rst;

    trigger_detector_if #(.WIDTH(8), .CNT_W(16)) u_bus ();

    trigger_detector #(.WIDTH(8), .CNT_W(16)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (u_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0]  c_rise, c_fall, c_mask, c_val;
    logic        c_and;
    int unsigned c_count, c_hold;
    logic [7:0]  m_prev;
    bit          m_prev_valid = 0;
    bit          m_active = 0, m_done = 0, m_trig = 0;
    int unsigned m_cnt = 0, m_time = 0;
    longint      m_cyc = 0, m_arm_cyc = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit model_match(input logic [7:0] d, input logic [7:0] p);
        bit any_en, any_hit, all_hit, lvl, r, f, en, h, edge_ok;
        any_en = 0; any_hit = 0; all_hit = 1; lvl = 1;
        for (int i = 0; i < 8; i++) begin
            r  = d[i] && !p[i];
            f  = !d[i] && p[i];
            en = c_rise[i] || c_fall[i];
            h  = (r && c_rise[i]) || (f && c_fall[i]);
            if (en) begin
                any_en = 1;
                if (h) any_hit = 1;
                else   all_hit = 0;
            end
            if (c_mask[i] && (d[i] != c_val[i])) lvl = 0;
        end
        edge_ok = !any_en ? 1'b1 : (c_and ? all_hit : any_hit);
        return edge_ok && lvl;
    endfunction

    task automatic model_edge();
        int unsigned tgt;
        m_trig = 0;
        if (rst) begin
            m_active = 0; m_done = 0; m_cnt = 0; m_time = 0;
            c_rise = '0; c_fall = '0; c_mask = '0; c_val = '0;
            c_and = 0; c_count = 0; c_hold = 0;
        end else if (u_bus.i_abort) begin
            m_active = 0; m_done = 0;
        end else if (u_bus.i_arm) begin
            c_rise = u_bus.i_rise_en;  c_fall = u_bus.i_fall_en;
            c_mask = u_bus.i_level_mask; c_val = u_bus.i_level_value;
            c_and = u_bus.i_combine_and;
            c_count = u_bus.i_count;   c_hold = u_bus.i_holdoff;
            m_cnt = 0; m_time = 0; m_active = 1; m_done = 0; m_arm_cyc = m_cyc;
        end else if (m_active && m_cyc >= m_arm_cyc + 1 + longint'(c_hold)) begin
            if (m_time < 65535) m_time++;
            if (model_match(u_bus.i_data, m_prev)) begin
                if (m_cnt < 65535) m_cnt++;
                tgt = (c_count == 0) ? 1 : c_count;
                if (m_cnt == tgt) begin
                    m_active = 0; m_done = 1; m_trig = 1;
                end
            end
        end
        m_prev = u_bus.i_data;
        m_prev_valid = 1;
        m_cyc++;
    endtask

    // One clock: check o_changed on settled inputs, clock, then check state.
    task automatic step();
        #1;
        if (m_prev_valid)
            check("changed", 32'(u_bus.o_changed), 32'(u_bus.i_data != m_prev));
        @(posedge clk);
        model_edge();
        #1;
        check("armed", 32'(u_bus.o_armed), 32'(m_active));
        check("triggered", 32'(u_bus.o_triggered), 32'(m_trig));
        check("done", 32'(u_bus.o_done), 32'(m_done));
        check("match_cnt", 32'(u_bus.o_match_cnt), m_cnt);
`ifdef TRIG_TIMESTAMP_EN
        check("trig_time", 32'(u_bus.o_trig_time), m_time);
`endif
    endtask

    task automatic set_cfg(input logic [7:0] rise, input logic [7:0] fall,
                           input logic [7:0] mask, input logic [7:0] val,
                           input logic comb, input logic [15:0] cnt,
                           input logic [15:0] hold);
        u_bus.i_rise_en = rise;  u_bus.i_fall_en = fall;
        u_bus.i_level_mask = mask; u_bus.i_level_value = val;
        u_bus.i_combine_and = comb;
        u_bus.i_count = cnt; u_bus.i_holdoff = hold;
    endtask

    task automatic arm();
        u_bus.i_arm = 1'b1;
        step();
        u_bus.i_arm = 1'b0;
    endtask

    task automatic drive(input logic [7:0] d);
        u_bus.i_data = d;
        step();
    endtask

    initial begin
        rst = 1'b1;
        u_bus.i_data = 8'hFF; u_bus.i_arm = 1'b0; u_bus.i_abort = 1'b0;
        set_cfg(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 16'd0, 16'd0);

        // 1: reset with all-ones data; no phantom edges afterwards
        repeat (3) step();
        check("rst_armed", 32'(u_bus.o_armed), 32'd0);
        check("rst_done", 32'(u_bus.o_done), 32'd0);
        rst = 1'b0;
        set_cfg(8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 16'd1, 16'd0);
        arm();
        repeat (4) drive(8'hFF);
        check("t1_cnt", 32'(u_bus.o_match_cnt), 32'd0);
        check("t1_changed", 32'(u_bus.o_changed), 32'd0);

        // 2: single rising edge on ch0
        u_bus.i_data = 8'h00; step();
        set_cfg(8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 16'd1, 16'd0);
        arm();
        drive(8'h00); drive(8'h00);
        drive(8'h01);
        check("t2_trig", 32'(u_bus.o_triggered), 32'd1);
        check("t2_done", 32'(u_bus.o_done), 32'd1);
        check("t2_cnt", 32'(u_bus.o_match_cnt), 32'd1);
        drive(8'h01);
        check("t2_pulse_end", 32'(u_bus.o_triggered), 32'd0);
        check("t2_done_hold", 32'(u_bus.o_done), 32'd1);

        // 3: AND combine needs both edges in the same cycle
        drive(8'h00);
        set_cfg(8'h03, 8'h00, 8'h00, 8'h00, 1'b1, 16'd1, 16'd0);
        arm();
        drive(8'h01); drive(8'h03);
        check("t3_no_trig", 32'(u_bus.o_done), 32'd0);
        drive(8'h00); drive(8'h03);
        check("t3_trig", 32'(u_bus.o_triggered), 32'd1);

        // 4: falls on ch7 qualified by ch0 level, count 3
        drive(8'h81);
        set_cfg(8'h00, 8'h80, 8'h01, 8'h00, 1'b0, 16'd3, 16'd0);
        arm();
        repeat (3) begin drive(8'h01); drive(8'h81); end
        check("t4_blocked", 32'(u_bus.o_match_cnt), 32'd0);
        drive(8'h80); drive(8'h00); drive(8'h80); drive(8'h00);
        check("t4_cnt2", 32'(u_bus.o_match_cnt), 32'd2);
        check("t4_not_done", 32'(u_bus.o_done), 32'd0);
        drive(8'h80); drive(8'h00);
        check("t4_trig", 32'(u_bus.o_triggered), 32'd1);
        check("t4_cnt3", 32'(u_bus.o_match_cnt), 32'd3);

        // 5: holdoff 5 ignores an early edge
        drive(8'h00);
        set_cfg(8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 16'd1, 16'd5);
        arm();
        drive(8'h00); drive(8'h01);
        check("t5_ignored", 32'(u_bus.o_match_cnt), 32'd0);
        drive(8'h00); drive(8'h00); drive(8'h00); drive(8'h00);
        drive(8'h01);
        check("t5_counted", 32'(u_bus.o_match_cnt), 32'd1);
        check("t5_done", 32'(u_bus.o_done), 32'd1);

        // 6: abort beats arm; reset during holdoff
        drive(8'h00);
        set_cfg(8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 16'd2, 16'd0);
        arm();
        drive(8'h00);
        u_bus.i_arm = 1'b1; u_bus.i_abort = 1'b1;
        step();
        u_bus.i_arm = 1'b0; u_bus.i_abort = 1'b0;
        check("t6_abort", 32'(u_bus.o_armed), 32'd0);
        set_cfg(8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 16'd1, 16'd10);
        arm();
        drive(8'h00);
        check("t6_holdoff", 32'(u_bus.o_armed), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        check("t6_rst", 32'(u_bus.o_armed), 32'd0);

        // Randomized: config inputs churn every cycle, only arm latches them
        for (int i = 0; i < 4000; i++) begin
            rst           = ($urandom_range(0, 299) == 0);
            u_bus.i_abort = ($urandom_range(0, 79) == 0);
            u_bus.i_arm   = ($urandom_range(0, 29) == 0);
            set_cfg(8'($urandom & $urandom), 8'($urandom & $urandom),
                    8'($urandom & $urandom & $urandom), 8'($urandom),
                    1'($urandom), 16'($urandom_range(0, 3)),
                    16'($urandom_range(0, 4)));
            u_bus.i_data = u_bus.i_data ^ 8'($urandom & $urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
